// File: rtl/core_pkg.sv
// Core-wide sizing constants and shared pipeline types.
// The register-read stage takes its default geometry from here.
package core_pkg;

    localparam int NUM_EX_PIPES = 3;
    localparam int NUM_PREGS    = 64;
    localparam int PREG_IDX_W   = $clog2(NUM_PREGS);
    localparam int RR_DATA_W    = 32;
    localparam int RR_UOP_W     = 64;

    // Operand packet at the default geometry. Non-default instances build an
    // equivalent struct from their own parameters.
    typedef struct packed {
        logic [RR_UOP_W-1:0]   uop;
        logic [PREG_IDX_W-1:0] dst;
        logic [RR_DATA_W-1:0]  src1_val;
        logic [RR_DATA_W-1:0]  src2_val;
    } rr_entry_t;

endpackage

// File: rtl/rr_bypass_mux.sv
// Forwards a same-cycle writeback over the register-file read value.
// When several ports hit, the highest port wins, matching the register-file write order.
module rr_bypass_mux
    import core_pkg::*;
#(
    parameter int PREG_W = PREG_IDX_W,
    parameter int DATA_W = 32,
    parameter int NWB    = NUM_EX_PIPES
) (
    input  logic [PREG_W-1:0]     src_reg,
    input  logic [DATA_W-1:0]     prf_val,
    input  logic [NWB-1:0]        wb_valid,
    input  logic [NWB*PREG_W-1:0] wb_dst_index,
    input  logic [NWB*DATA_W-1:0] wb_dst_val,
    output logic [DATA_W-1:0]     fwd_val
);

    logic [NWB-1:0] hit;

    generate
        for (genvar gi = 0; gi < NWB; gi++) begin : g_hit
            assign hit[gi] = wb_valid[gi] && (wb_dst_index[gi*PREG_W +: PREG_W] == src_reg);
        end
    endgenerate

    // Ascending scan, so the last hit seen belongs to the highest port.
    always_comb begin
        fwd_val = prf_val;
        for (int i = 0; i < NWB; i++) begin
            if (hit[i]) begin
                fwd_val = wb_dst_val[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/reg_read_stage.sv
// Register-read stage: reads the register file, forwards writebacks, and hands
// operand packets to execute through an output register plus one skid entry.
module reg_read_stage
    import core_pkg::*;
#(
    parameter int PREG_W = PREG_IDX_W,
    parameter int DATA_W = 32,
    parameter int UOP_W  = 64,
    parameter int NWB    = NUM_EX_PIPES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic [PREG_W-1:0]     iss_src1_reg,
    input  logic [PREG_W-1:0]     iss_src2_reg,
    input  logic [PREG_W-1:0]     iss_dst_reg,
    input  logic [UOP_W-1:0]      iss_uop,
    output logic [PREG_W-1:0]     prf_src1_reg,
    output logic [PREG_W-1:0]     prf_src2_reg,
    input  logic [DATA_W-1:0]     prf_src1_val,
    input  logic [DATA_W-1:0]     prf_src2_val,
    input  logic [NWB-1:0]        wb_valid,
    input  logic [NWB*PREG_W-1:0] wb_dst_index,
    input  logic [NWB*DATA_W-1:0] wb_dst_val,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_W-1:0]     ex_src1_val,
    output logic [DATA_W-1:0]     ex_src2_val,
    output logic [PREG_W-1:0]     ex_dst_reg,
    output logic [UOP_W-1:0]      ex_uop
);

    typedef struct packed {
        logic [UOP_W-1:0]  uop;
        logic [PREG_W-1:0] dst;
        logic [DATA_W-1:0] src1_val;
        logic [DATA_W-1:0] src2_val;
    } entry_t;

    entry_t out_reg, out_next;
    entry_t skid_reg, skid_next;
    entry_t new_entry;
    logic   out_valid_reg, out_valid_next;
    logic   skid_valid_reg, skid_valid_next;
    logic   iss_ready_reg;
    logic   iss_fire, ex_fire;
    logic [DATA_W-1:0] fwd1_val, fwd2_val;

    assign prf_src1_reg = iss_src1_reg;
    assign prf_src2_reg = iss_src2_reg;

    rr_bypass_mux #(.PREG_W(PREG_W), .DATA_W(DATA_W), .NWB(NWB)) u_byp1 (
        .src_reg      (iss_src1_reg),
        .prf_val      (prf_src1_val),
        .wb_valid     (wb_valid),
        .wb_dst_index (wb_dst_index),
        .wb_dst_val   (wb_dst_val),
        .fwd_val      (fwd1_val)
    );

    rr_bypass_mux #(.PREG_W(PREG_W), .DATA_W(DATA_W), .NWB(NWB)) u_byp2 (
        .src_reg      (iss_src2_reg),
        .prf_val      (prf_src2_val),
        .wb_valid     (wb_valid),
        .wb_dst_index (wb_dst_index),
        .wb_dst_val   (wb_dst_val),
        .fwd_val      (fwd2_val)
    );

    assign iss_fire  = iss_valid && iss_ready_reg;
    assign ex_fire   = out_valid_reg && ex_ready;
    assign new_entry = '{uop: iss_uop, dst: iss_dst_reg, src1_val: fwd1_val, src2_val: fwd2_val};

    // SKID only fills while OUT is valid, so OUT is always the older entry.
    always_comb begin
        out_next        = out_reg;
        skid_next       = skid_reg;
        out_valid_next  = out_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (ex_fire) begin
            if (skid_valid_reg) begin
                out_next        = skid_reg;
                skid_valid_next = iss_fire;
                if (iss_fire) skid_next = new_entry;
            end else begin
                out_valid_next = iss_fire;
                if (iss_fire) out_next = new_entry;
            end
        end else if (out_valid_reg) begin
            if (iss_fire) begin
                skid_next       = new_entry;
                skid_valid_next = 1'b1;
            end
        end else if (iss_fire) begin
            out_next       = new_entry;
            out_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg        <= '0;
            skid_reg       <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            iss_ready_reg  <= 1'b1;
        end else begin
            out_reg        <= out_next;
            skid_reg       <= skid_next;
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            iss_ready_reg  <= !skid_valid_next;
        end
    end

    assign iss_ready   = iss_ready_reg;
    assign ex_valid    = out_valid_reg;
    assign ex_src1_val = out_reg.src1_val;
    assign ex_src2_val = out_reg.src2_val;
    assign ex_dst_reg  = out_reg.dst;
    assign ex_uop      = out_reg.uop;

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Register-read pipeline stage for one execute pipe, sitting between issue and execute. It drives the source physical-register indices to the physical register file's combinational read port and captures the returned operands. Same-cycle writebacks are forwarded around the register-file write latency. It hands a complete operand packet to execute through a valid/ready handshake, with a two-entry skid buffer so that `iss_ready` is a registered signal. One instance is built per execute pipe (`NUM_EX_PIPES` total).

## Interface
Parameters:
- `PREG_W`, default `$clog2(NUM_PREGS)`: physical register index width.
- `DATA_W`, default 32: operand width.
- `UOP_W`, default 64: opaque uop payload width, passed through unmodified.
- `NWB`, default `NUM_EX_PIPES`: number of writeback/bypass ports.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all held uops (mispredict recovery).
- `iss_valid` in 1: issue offers a uop.
- `iss_ready` out 1: stage accepts; registered.
- `iss_src1_reg`, `iss_src2_reg` in `PREG_W`: source physical registers.
- `iss_dst_reg` in `PREG_W`: destination physical register.
- `iss_uop` in `UOP_W`: payload.
- `prf_src1_reg`, `prf_src2_reg` out `PREG_W`: register-file read indices.
- `prf_src1_val`, `prf_src2_val` in `DATA_W`: register-file read data, combinational from the indices.
- `wb_valid` in `NWB`: per-pipe writeback valid (the same signals that write the register file).
- `wb_dst_index` in `NWB*PREG_W`: writeback indices, packed with port i at `[i*PREG_W +: PREG_W]`.
- `wb_dst_val` in `NWB*DATA_W`: writeback data, packed in the same way.
- `ex_valid` out 1: operand packet available.
- `ex_ready` in 1: execute accepts.
- `ex_src1_val`, `ex_src2_val` out `DATA_W`: captured operands.
- `ex_dst_reg` out `PREG_W`, `ex_uop` out `UOP_W`: pass-through fields.

## Operation
- Issue fire: `iss_valid && iss_ready`. Execute fire: `ex_valid && ex_ready`.
- `prf_srcN_reg` is driven directly from `iss_srcN_reg`. It is read in the same cycle as the issue offer.
- Captured operand for each source:
  - If any `wb_valid[i]` is set and `wb_dst_index[i]` equals the source index, capture `wb_dst_val[i]`.
  - Otherwise capture `prf_srcN_val`.
  - If several ports match, the highest i wins. This is the register file's write priority.
- Index 0 is an ordinary register, with no zero-hardwiring.
- Storage:
  - Output register OUT drives the `ex_*` signals.
  - Skid register SKID holds one overflow entry.
  - Each entry holds the uop, the dst index, and both captured values.
- Operands are frozen once captured. A physical register is not rewritten while a consumer holds it, so there is no re-read while stalled.
- Per-cycle update when there is no flush or reset:
  - Execute fire: OUT receives SKID if SKID is valid, otherwise the issue-fire entry, otherwise becomes invalid. If SKID moved to OUT, SKID receives the issue-fire entry, if any.
  - No execute fire with OUT valid: an issue-fire entry goes to SKID.
  - OUT invalid: an issue-fire entry goes to OUT.
- `iss_ready` = !SKID.valid, registered. If OUT is valid, unaccepted, and SKID is full, no issue is accepted.
- `flush`:
  - Next cycle, OUT.valid = SKID.valid = 0 and `iss_ready` = 1.
  - An issue fire coinciding with the flush is dropped.
  - An execute fire coinciding with the flush still counts as consumed.
- Reset values:
  - `ex_valid` = 0, `iss_ready` = 1.
  - `ex_src1_val`, `ex_src2_val`, `ex_dst_reg`, `ex_uop` = 0.
  - `prf_srcN_reg` follow `iss_srcN_reg`.
  - Reset overrides flush.

## Timing
- Latency: an issue fire in cycle N gives `ex_valid` in cycle N+1.
- Throughput: one uop/cycle while `ex_ready` is held high.
- Bypass window:
  - A writeback in cycle N is visible in the register file from N+1.
  - A read in cycle N therefore uses the forward path, and the captured value equals `wb_dst_val`.
- Back-pressure:
  - `ex_ready` low at N with OUT full: an issue fire at N fills SKID, and `iss_ready` drops at N+1.
  - `ex_ready` high again at M: SKID moves to OUT at M+1, and `iss_ready` rises at M+1.
- `ex_*` data is stable while `ex_valid && !ex_ready`.
- No combinational path from `ex_ready` to `iss_ready`.

## Structure
- `CORE_PKG` gains:
  - `PREG_IDX_W` = `$clog2(NUM_PREGS)`.
  - typedef `rr_entry_t` {uop, dst, src1_val, src2_val}.
  - `NUM_EX_PIPES` and `NUM_PREGS` are reused.
- Sub-module `rr_bypass_mux`:
  - One instance per source operand.
  - Inputs: source index, register-file value, `wb_*` arrays.
  - Output: forwarded value; purely combinational.
- OUT/SKID control lives in the top module.

## Test plan
- Single uop, src1=5, src2=9, register file holds p5=0x11, p9=0x22, `ex_ready`=1 -> next cycle `ex_valid`=1 with values 0x11/0x22; `ex_valid`=0 the cycle after.
- Issue src1=7 while `wb_valid[1]`=1, index 7, value 0xDEAD_BEEF; register file p7=0 -> `ex_src1_val`=0xDEADBEEF.
- `wb_valid[0]` and `wb_valid[2]` both hit index 3 with 0xA and 0xC -> captured value is 0xC.
- `ex_ready`=0 for 4 cycles with `iss_valid` held high -> exactly 2 uops accepted and `iss_ready`=0 from cycle 2; on release the uops drain in order, one per cycle, with values unchanged.
- OUT and SKID full, assert `flush` with `iss_valid`=1 -> next cycle `ex_valid`=0, `iss_ready`=1, and the flush-cycle uop never appears.
- `rst` asserted mid-stall -> next cycle `ex_valid`=0, all `ex_*` data 0, `iss_ready`=1.
